vga_axi_regs: RTL

Parametrised AXI4-Lite slave register bank; next generation of the fixed four-register VGA control interface. Provides NUM_RW read/write control registers with byte strobes and NUM_RO read-only status registers. Optional frame-synchronous shadowing makes control values reach the VGA/game logic only at vblank, so there is no mid-frame tearing. Sits between the AXI interconnect (master VIP in simulation) and the VGA timing/render logic.

---
 rtl/vga_axi_regs_pkg.sv | 29 ++
 rtl/vga_axi_regs_if.sv | 39 +++
 rtl/vga_axi_regs_shadow.sv | 36 +++
 rtl/vga_axi_regs.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_axi_regs_pkg.sv
// Shared constants, FSM state types and address decode helper for the
// vga_axi_regs AXI4-Lite register bank.
package vga_axi_regs_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WS_IDLE,
    WS_COMMIT,
    WS_RESP
  } ws_e;

  typedef enum logic {
    RS_IDLE,
    RS_DATA
  } rs_e;

  // Word index from a byte address: drop bits above the bus address width
  // and the byte-offset bits below the word boundary.
  function automatic int unsigned addr_to_idx(input logic [63:0] addr,
                                              input int unsigned addr_w,
                                              input int unsigned lsb);
    logic [63:0] masked;
    masked = addr & ((64'd1 << addr_w) - 64'd1);
    return 32'(masked >> lsb);
  endfunction

endpackage

// File: rtl/vga_axi_regs_if.sv
// AXI4-Lite channel bundle between the interconnect and the register bank.
interface vga_axi_regs_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 6
);

  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/vga_axi_regs_shadow.sv
// Frame-synchronous copy of the working registers; a plain wire-through
// when shadowing is disabled.
module vga_axi_regs_shadow #(
  parameter int unsigned DW     = 32,
  parameter int unsigned NUM_RW = 8,
  parameter int unsigned SHADOW = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_sync,
  input  logic [NUM_RW*DW-1:0] work,
  output logic [NUM_RW*DW-1:0] reg_out
);

  generate
    if (SHADOW != 0) begin : g_shadow
      logic [NUM_RW*DW-1:0] shadow_q;

      // Loads pre-edge working values, so a same-cycle commit waits a frame.
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_q <= '0;
        end else if (frame_sync) begin
          shadow_q <= work;
        end
      end

      assign reg_out = shadow_q;
    end else begin : g_bypass
      logic unused_ok;
      assign unused_ok = ^{clk, rst, frame_sync};
      assign reg_out   = work;
    end
  endgenerate

endmodule

// File: rtl/vga_axi_regs.sv
// AXI4-Lite slave register bank: NUM_RW byte-strobed control registers,
// NUM_RO status registers, optional vblank-synchronous output shadowing.
module vga_axi_regs
  import vga_axi_regs_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_RW             = 8,
  parameter int unsigned NUM_RO             = 4,
  parameter int unsigned SHADOW             = 1
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESET,
  vga_axi_regs_if.slave                        s_axi,
  output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_RW-1:0]                    reg_wr_pulse,
  input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0] ro_in,
  input  logic                                 frame_sync
);

  localparam int unsigned DW  = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW  = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned NB  = DW / 8;
  localparam int unsigned LSB = $clog2(NB);

  logic clk;
  logic rst;
  assign clk = S_AXI_ACLK;
  assign rst = S_AXI_ARESET;

  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot};

  logic [DW-1:0]        work_q [NUM_RW];
  logic [NUM_RW*DW-1:0] work_flat;

  // ---------------- write channel ----------------
  ws_e             ws, ws_n;
  logic            aw_held, aw_held_n, w_held, w_held_n;
  logic [AW-1:0]   awaddr_q, awaddr_n;
  logic [DW-1:0]   wdata_q, wdata_n;
  logic [NB-1:0]   wstrb_q, wstrb_n;
  logic            awready_n, wready_n, bvalid_n;
  logic [1:0]      bresp_n;
  logic            commit_c;
  int unsigned     widx_c;
  logic            wr_rw_c;

  assign widx_c  = addr_to_idx(64'(awaddr_q), AW, LSB);
  assign wr_rw_c = (widx_c < NUM_RW);

  always_ff @(posedge clk) begin
    if (rst) begin
      ws            <= WS_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= RESP_OKAY;
    end else begin
      ws            <= ws_n;
      aw_held       <= aw_held_n;
      w_held        <= w_held_n;
      awaddr_q      <= awaddr_n;
      wdata_q       <= wdata_n;
      wstrb_q       <= wstrb_n;
      s_axi.awready <= awready_n;
      s_axi.wready  <= wready_n;
      s_axi.bvalid  <= bvalid_n;
      s_axi.bresp   <= bresp_n;
    end
  end

  // AW and W are latched independently; commit only once both are held.
  always_comb begin
    ws_n      = ws;
    aw_held_n = aw_held;
    w_held_n  = w_held;
    awaddr_n  = awaddr_q;
    wdata_n   = wdata_q;
    wstrb_n   = wstrb_q;
    awready_n = s_axi.awready;
    wready_n  = s_axi.wready;
    bvalid_n  = s_axi.bvalid;
    bresp_n   = s_axi.bresp;
    commit_c  = 1'b0;
    unique case (ws)
      WS_IDLE: begin
        if (s_axi.awvalid && s_axi.awready) begin
          aw_held_n = 1'b1;
          awaddr_n  = s_axi.awaddr;
          awready_n = 1'b0;
        end else if (!aw_held) begin
          awready_n = 1'b1;
        end
        if (s_axi.wvalid && s_axi.wready) begin
          w_held_n = 1'b1;
          wdata_n  = s_axi.wdata;
          wstrb_n  = s_axi.wstrb;
          wready_n = 1'b0;
        end else if (!w_held) begin
          wready_n = 1'b1;
        end
        if (aw_held && w_held) ws_n = WS_COMMIT;
      end
      WS_COMMIT: begin
        commit_c  = 1'b1;
        bvalid_n  = 1'b1;
        bresp_n   = wr_rw_c ? RESP_OKAY : RESP_SLVERR;
        aw_held_n = 1'b0;
        w_held_n  = 1'b0;
        ws_n      = WS_RESP;
      end
      WS_RESP: begin
        if (s_axi.bready) begin
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
          ws_n      = WS_IDLE;
        end
      end
      default: ws_n = WS_IDLE;
    endcase
  end

  // Working registers and per-register commit strobe (fires even with WSTRB=0).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_RW; i++) work_q[i] <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      for (int unsigned i = 0; i < NUM_RW; i++) begin
        if (commit_c && (widx_c == i)) begin
          reg_wr_pulse[i] <= 1'b1;
          for (int unsigned b = 0; b < NB; b++) begin
            if (wstrb_q[b]) work_q[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
          end
        end
      end
    end
  end

  // ---------------- read channel ----------------
  rs_e           rs, rs_n;
  logic [AW-1:0] araddr_q, araddr_n;
  logic          arready_n, rvalid_n;
  logic [DW-1:0] rdata_n, rd_val_c;
  logic [1:0]    rresp_n, rd_resp_c;
  int unsigned   ridx_c;

  assign ridx_c = addr_to_idx(64'(araddr_q), AW, LSB);

  always_comb begin
    rd_val_c  = '0;
    rd_resp_c = RESP_SLVERR;
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (ridx_c == i) begin
        rd_val_c  = work_q[i];
        rd_resp_c = RESP_OKAY;
      end
    end
    for (int unsigned i = 0; i < NUM_RO; i++) begin
      if (ridx_c == NUM_RW + i) begin
        rd_val_c  = ro_in[i*DW +: DW];
        rd_resp_c = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs            <= RS_IDLE;
      araddr_q      <= '0;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= RESP_OKAY;
    end else begin
      rs            <= rs_n;
      araddr_q      <= araddr_n;
      s_axi.arready <= arready_n;
      s_axi.rvalid  <= rvalid_n;
      s_axi.rdata   <= rdata_n;
      s_axi.rresp   <= rresp_n;
    end
  end

  // RDATA/RRESP are captured once and then held until the R handshake.
  always_comb begin
    rs_n      = rs;
    araddr_n  = araddr_q;
    arready_n = s_axi.arready;
    rvalid_n  = s_axi.rvalid;
    rdata_n   = s_axi.rdata;
    rresp_n   = s_axi.rresp;
    unique case (rs)
      RS_IDLE: begin
        if (s_axi.arvalid && s_axi.arready) begin
          araddr_n  = s_axi.araddr;
          arready_n = 1'b0;
          rs_n      = RS_DATA;
        end else begin
          arready_n = 1'b1;
        end
      end
      RS_DATA: begin
        if (!s_axi.rvalid) begin
          rvalid_n = 1'b1;
          rdata_n  = rd_val_c;
          rresp_n  = rd_resp_c;
        end else if (s_axi.rready) begin
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
          rs_n      = RS_IDLE;
        end
      end
      default: rs_n = RS_IDLE;
    endcase
  end

  // ---------------- outputs to VGA logic ----------------
  for (genvar g = 0; g < NUM_RW; g++) begin : g_flat
    assign work_flat[g*DW +: DW] = work_q[g];
  end

  vga_axi_regs_shadow #(
    .DW     (DW),
    .NUM_RW (NUM_RW),
    .SHADOW (SHADOW)
  ) u_shadow (
    .clk        (clk),
    .rst        (rst),
    .frame_sync (frame_sync),
    .work       (work_flat),
    .reg_out    (reg_out)
  );

endmodule
